// File: rtl/branch_pkg.sv
// Shared types for the branch resolution slice.
//   pred_entry_t : one queued fetch-time prediction {pc, pred_taken, pred_target}
//   INSN_BYTES   : fall-through distance used when redirecting a not-taken branch
package branch_pkg;

  localparam int unsigned PC_WIDTH   = 32;
  localparam int unsigned INSN_BYTES = 4;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic                pred_taken;
    logic [PC_WIDTH-1:0] pred_target;
  } pred_entry_t;

endpackage

// File: rtl/branch_resolution_unit_pred_fifo.sv
// In-order queue of in-flight branch predictions.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   push         : write push_entry at the tail (ignored when full)
//   push_entry   : entry to enqueue
//   pop          : drop the head entry (ignored when empty)
//   clear        : empty the queue; wins over push and pop
//   full, empty  : occupancy flags
//   head         : oldest entry, valid when empty = 0
module pred_fifo
  import branch_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned PTR_WIDTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  pred_entry_t push_entry,
  input  logic        pop,
  input  logic        clear,
  output logic        full,
  output logic        empty,
  output pred_entry_t head
);

  pred_entry_t          mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [PTR_WIDTH:0]   count;

  logic do_push;
  logic do_pop;

  assign full    = (count == (PTR_WIDTH+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_WIDTH'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_WIDTH+1)'(1);
        2'b01:   count <= count - (PTR_WIDTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolution_unit.sv
// Branch resolution unit: queues fetch-time predictions, checks them against
// execute-stage outcomes, drives predictor/BTB updates, and flushes on mispredict.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   alloc_valid/ready/pc/pred_taken/pred_target : prediction enqueue from fetch
//   res_valid/taken/target           : in-order resolution from execute
//   update_predictor, update_btb     : one-cycle update pulses
//   actually_taken, resolved_pc, resolved_pc_target : registered resolution info
//   flush, redirect_pc               : one-cycle mispredict redirect
//   branch_count, mispredict_count   : saturating counters
//   res_underflow                    : sticky, resolution seen with empty queue
module branch_resolution_unit
  import branch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned PTR_WIDTH   = 2,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_valid,
  output logic                   alloc_ready,
  input  logic [DATA_WIDTH-1:0]  alloc_pc,
  input  logic                   alloc_pred_taken,
  input  logic [DATA_WIDTH-1:0]  alloc_pred_target,
  input  logic                   res_valid,
  input  logic                   res_taken,
  input  logic [DATA_WIDTH-1:0]  res_target,
  output logic                   update_predictor,
  output logic                   update_btb,
  output logic                   actually_taken,
  output logic [DATA_WIDTH-1:0]  resolved_pc,
  output logic [DATA_WIDTH-1:0]  resolved_pc_target,
  output logic                   flush,
  output logic [DATA_WIDTH-1:0]  redirect_pc,
  output logic [COUNT_WIDTH-1:0] branch_count,
  output logic [COUNT_WIDTH-1:0] mispredict_count,
  output logic                   res_underflow
);

  pred_entry_t alloc_entry;
  pred_entry_t head;
  logic        full;
  logic        empty;
  logic        resolve;
  logic        mispredict;
  logic        push;

  assign alloc_entry = '{pc: alloc_pc, pred_taken: alloc_pred_taken, pred_target: alloc_pred_target};

  // flush only goes high in the cycle after a clear, so the queue is empty and
  // gating alloc_ready with it merely keeps fetch quiet during the redirect.
  assign alloc_ready = !full && !flush;
  assign resolve     = res_valid && !empty;
  assign mispredict  = resolve &&
                       ((res_taken != head.pred_taken) ||
                        (res_taken && head.pred_taken && (res_target != head.pred_target)));
  assign push        = alloc_valid && alloc_ready;

  pred_fifo #(
    .DEPTH     (DEPTH),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_pred_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (alloc_entry),
    .pop        (resolve),
    .clear      (mispredict),
    .full       (full),
    .empty      (empty),
    .head       (head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      update_predictor   <= 1'b0;
      update_btb         <= 1'b0;
      actually_taken     <= 1'b0;
      resolved_pc        <= '0;
      resolved_pc_target <= '0;
      flush              <= 1'b0;
      redirect_pc        <= '0;
      branch_count       <= '0;
      mispredict_count   <= '0;
      res_underflow      <= 1'b0;
    end else begin
      update_predictor <= resolve;
      update_btb       <= resolve && res_taken;
      flush            <= mispredict;

      if (resolve) begin
        actually_taken     <= res_taken;
        resolved_pc        <= head.pc;
        resolved_pc_target <= res_target;
        if (branch_count != '1) begin
          branch_count <= branch_count + COUNT_WIDTH'(1);
        end
      end

      if (mispredict) begin
        redirect_pc <= res_taken ? res_target : head.pc + DATA_WIDTH'(INSN_BYTES);
        if (mispredict_count != '1) begin
          mispredict_count <= mispredict_count + COUNT_WIDTH'(1);
        end
      end

      if (res_valid && empty) begin
        res_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolution_unit.sv
module tb_branch_resolution_unit;

  logic        clk;
  logic        rst;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [31:0] alloc_pc;
  logic        alloc_pred_taken;
  logic [31:0] alloc_pred_target;
  logic        res_valid;
  logic        res_taken;
  logic [31:0] res_target;
  logic        update_predictor;
  logic        update_btb;
  logic        actually_taken;
  logic [31:0] resolved_pc;
  logic [31:0] resolved_pc_target;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;
  logic        res_underflow;

  int unsigned checks;
  int unsigned errors;

  branch_resolution_unit #(
    .DATA_WIDTH  (32),
    .DEPTH       (4),
    .PTR_WIDTH   (2),
    .COUNT_WIDTH (32)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .alloc_valid        (alloc_valid),
    .alloc_ready        (alloc_ready),
    .alloc_pc           (alloc_pc),
    .alloc_pred_taken   (alloc_pred_taken),
    .alloc_pred_target  (alloc_pred_target),
    .res_valid          (res_valid),
    .res_taken          (res_taken),
    .res_target         (res_target),
    .update_predictor   (update_predictor),
    .update_btb         (update_btb),
    .actually_taken     (actually_taken),
    .resolved_pc        (resolved_pc),
    .resolved_pc_target (resolved_pc_target),
    .flush              (flush),
    .redirect_pc        (redirect_pc),
    .branch_count       (branch_count),
    .mispredict_count   (mispredict_count),
    .res_underflow      (res_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic do_alloc(input logic [31:0] pc, input logic taken, input logic [31:0] target);
    alloc_valid       = 1'b1;
    alloc_pc          = pc;
    alloc_pred_taken  = taken;
    alloc_pred_target = target;
    step();
    alloc_valid = 1'b0;
  endtask

  task automatic do_resolve(input logic taken, input logic [31:0] target);
    res_valid  = 1'b1;
    res_taken  = taken;
    res_target = target;
    step();
    res_valid = 1'b0;
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    rst               = 1'b0;
    alloc_valid       = 1'b0;
    alloc_pc          = '0;
    alloc_pred_taken  = 1'b0;
    alloc_pred_target = '0;
    res_valid         = 1'b0;
    res_taken         = 1'b0;
    res_target        = '0;

    // Reset state
    do_reset();
    check_val("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    check_val("rst_update_pred", 32'(update_predictor), 32'd0);
    check_val("rst_flush", 32'(flush), 32'd0);
    check_val("rst_redirect", redirect_pc, 32'h0);
    check_val("rst_resolved_pc", resolved_pc, 32'h0);
    check_val("rst_branch_cnt", branch_count, 32'd0);
    check_val("rst_mispred_cnt", mispredict_count, 32'd0);
    check_val("rst_underflow", 32'(res_underflow), 32'd0);

    // Correct not-taken
    do_alloc(32'h100, 1'b0, 32'h0);
    do_resolve(1'b0, 32'h0);
    check_val("nt_update_pred", 32'(update_predictor), 32'd1);
    check_val("nt_update_btb", 32'(update_btb), 32'd0);
    check_val("nt_act_taken", 32'(actually_taken), 32'd0);
    check_val("nt_resolved_pc", resolved_pc, 32'h100);
    check_val("nt_flush", 32'(flush), 32'd0);
    check_val("nt_branch_cnt", branch_count, 32'd1);
    check_val("nt_mispred_cnt", mispredict_count, 32'd0);
    step();
    check_val("nt_pulse_drop", 32'(update_predictor), 32'd0);
    check_val("nt_pc_hold", resolved_pc, 32'h100);

    // Direction mispredict
    do_alloc(32'h200, 1'b0, 32'h0);
    do_resolve(1'b1, 32'h400);
    check_val("dir_flush", 32'(flush), 32'd1);
    check_val("dir_redirect", redirect_pc, 32'h400);
    check_val("dir_update_btb", 32'(update_btb), 32'd1);
    check_val("dir_act_taken", 32'(actually_taken), 32'd1);
    check_val("dir_res_target", resolved_pc_target, 32'h400);
    check_val("dir_resolved_pc", resolved_pc, 32'h200);
    check_val("dir_mispred_cnt", mispredict_count, 32'd1);
    check_val("dir_branch_cnt", branch_count, 32'd2);
    check_val("dir_ready_low", 32'(alloc_ready), 32'd0);
    step();
    check_val("dir_flush_drop", 32'(flush), 32'd0);
    check_val("dir_ready_back", 32'(alloc_ready), 32'd1);

    // Target mispredict with wrong-path purge, plus an alloc in the same cycle
    do_alloc(32'h300, 1'b1, 32'h500);
    do_alloc(32'h304, 1'b0, 32'h0);
    do_alloc(32'h308, 1'b0, 32'h0);
    alloc_valid       = 1'b1;
    alloc_pc          = 32'h30C;
    alloc_pred_taken  = 1'b0;
    alloc_pred_target = 32'h0;
    do_resolve(1'b1, 32'h600);
    alloc_valid = 1'b0;
    check_val("tgt_flush", 32'(flush), 32'd1);
    check_val("tgt_redirect", redirect_pc, 32'h600);
    check_val("tgt_resolved_pc", resolved_pc, 32'h300);
    check_val("tgt_mispred_cnt", mispredict_count, 32'd2);
    check_val("tgt_branch_cnt", branch_count, 32'd3);
    step();
    check_val("tgt_flush_drop", 32'(flush), 32'd0);
    do_resolve(1'b0, 32'h0);
    check_val("tgt_no_update", 32'(update_predictor), 32'd0);
    check_val("tgt_underflow", 32'(res_underflow), 32'd1);
    check_val("tgt_branch_hold", branch_count, 32'd3);
    step();
    check_val("tgt_uf_sticky", 32'(res_underflow), 32'd1);

    // Full queue, no bypass on simultaneous pop
    do_reset();
    check_val("full_uf_cleared", 32'(res_underflow), 32'd0);
    for (int unsigned i = 0; i < 4; i++) begin
      do_alloc(32'h1000 + 32'(i * 4), 1'b0, 32'h0);
    end
    check_val("full_ready_low", 32'(alloc_ready), 32'd0);
    alloc_valid       = 1'b1;
    alloc_pc          = 32'h1010;
    alloc_pred_taken  = 1'b0;
    alloc_pred_target = 32'h0;
    do_resolve(1'b0, 32'h0);
    alloc_valid = 1'b0;
    check_val("full_pop_pc", resolved_pc, 32'h1000);
    check_val("full_ready_back", 32'(alloc_ready), 32'd1);
    for (int unsigned i = 1; i < 4; i++) begin
      do_resolve(1'b0, 32'h0);
      check_val("full_drain_pc", resolved_pc, 32'h1000 + 32'(i * 4));
      check_val("full_drain_upd", 32'(update_predictor), 32'd1);
    end
    do_resolve(1'b0, 32'h0);
    check_val("full_5th_dropped", 32'(update_predictor), 32'd0);
    check_val("full_underflow", 32'(res_underflow), 32'd1);
    check_val("full_branch_cnt", branch_count, 32'd4);

    // Not-taken mispredict at address wrap
    do_reset();
    do_alloc(32'hFFFF_FFFC, 1'b1, 32'h10);
    do_resolve(1'b0, 32'h0);
    check_val("wrap_flush", 32'(flush), 32'd1);
    check_val("wrap_redirect", redirect_pc, 32'h0000_0000);
    check_val("wrap_update_btb", 32'(update_btb), 32'd0);
    check_val("wrap_mispred_cnt", mispredict_count, 32'd1);
    step();

    // Reset mid-flight beats a mispredicting resolve and an alloc
    do_alloc(32'h2000, 1'b1, 32'h20);
    do_alloc(32'h2004, 1'b1, 32'h30);
    rst               = 1'b1;
    alloc_valid       = 1'b1;
    alloc_pc          = 32'h2008;
    alloc_pred_taken  = 1'b0;
    alloc_pred_target = 32'h0;
    do_resolve(1'b1, 32'h40);
    rst         = 1'b0;
    alloc_valid = 1'b0;
    check_val("mid_flush_rst", 32'(flush), 32'd0);
    check_val("mid_update_rst", 32'(update_predictor), 32'd0);
    check_val("mid_ready_rst", 32'(alloc_ready), 32'd1);
    check_val("mid_branch_cnt", branch_count, 32'd0);
    check_val("mid_mispred_cnt", mispredict_count, 32'd0);
    step();
    check_val("mid_flush_next", 32'(flush), 32'd0);
    check_val("mid_update_next", 32'(update_predictor), 32'd0);
    do_resolve(1'b1, 32'h20);
    check_val("mid_queue_empty", 32'(res_underflow), 32'd1);
    check_val("mid_no_update", 32'(update_predictor), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
